serail_ctrl: RTL and testbench

//  Bridges the CPU memory bus to the serial device. Serial-mapped MEM-stage stores are queued as bytes in a TX FIFO.
//  An internal FSM drains the FIFO into the serial device with its ce/we/ready handshake.
//  The CPU sees a status register and a one-cycle ready pulse per access.

---
 rtl/serail_ctrl_pkg.sv | 24 ++
 rtl/serail_fifo.sv | 65 ++++++
 rtl/serail_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_serail_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serail_ctrl_pkg.sv
// Shared constants for the serial bridge: CPU-side register map, STATUS bit
// positions, drain FSM state encodings and the CPU address decode type.
package serail_ctrl_pkg;

  localparam logic [3:0] SERAIL_DATA_ADDR = 4'h0;
  localparam logic [3:0] SERAIL_STAT_ADDR = 4'h4;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_TMO_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;

  localparam logic [1:0] SC_IDLE = 2'd0;
  localparam logic [1:0] SC_SEND = 2'd1;
  localparam logic [1:0] SC_GAP  = 2'd2;

  typedef enum logic [1:0] {
    BUS_DATA = 2'd0,
    BUS_STAT = 2'd1,
    BUS_NONE = 2'd2
  } bus_sel_e;

endpackage

// File: rtl/serail_fifo.sv
// Synchronous byte FIFO holding the TX bytes between the CPU and the drain FSM.
// Head is presented combinationally on dout; pointers wrap naturally.
module serail_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy next-state; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/serail_ctrl.sv
// CPU-bus to serial-device bridge: decodes DATA/STATUS accesses, queues bytes
// in a TX FIFO and drains them through the device ce/we/ready handshake.
// Optional build macro SERAIL_CTRL_DROP_ON_FULL_EN: DATA writes while full are
// acked and discarded (setting sticky overflow) instead of stalling.
module serail_ctrl
  import serail_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_ce_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_ready_o,
  output logic              serail_ce_o,
  output logic              serail_we_o,
  output logic [ADDR_W-1:0] serail_addr_o,
  output logic [DATA_W-1:0] serail_data_o,
  input  logic              serail_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  logic              armed_q, armed_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d;
  logic [1:0]        state_q, state_d;
  logic              ce_q, ce_d, we_q, we_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  bus_sel_e sel;
  logic     req, wr_data, accept, stat_rd, ovf_set, tmo_set;
  logic     unused_hi;

  function automatic logic [DATA_W-1:0] build_status(input logic empty, full, ovf, tmo,
                                                     input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] s;
    s                          = '0;
    s[STAT_EMPTY_BIT]          = empty;
    s[STAT_FULL_BIT]           = full;
    s[STAT_OVF_BIT]            = ovf;
    s[STAT_TMO_BIT]            = tmo;
    s[STAT_CNT_LSB +: CNT_W]   = cnt;
    return s;
  endfunction

  serail_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus_data_i[7:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign unused_hi     = ^bus_data_i[DATA_W-1:8];
  assign bus_data_o    = rdata_q;
  assign bus_ready_o   = rdy_q;
  assign serail_ce_o   = ce_q;
  assign serail_we_o   = we_q;
  assign serail_addr_o = '0;
  assign serail_data_o = sdata_q;

  // CPU address decode and accept qualification (one accept per ce assertion).
  always_comb begin
    if (bus_addr_i == ADDR_W'(SERAIL_DATA_ADDR))      sel = BUS_DATA;
    else if (bus_addr_i == ADDR_W'(SERAIL_STAT_ADDR)) sel = BUS_STAT;
    else                                              sel = BUS_NONE;
    req     = bus_ce_i & armed_q;
    wr_data = req & bus_we_i & (sel == BUS_DATA);
`ifdef SERAIL_CTRL_DROP_ON_FULL_EN
    accept  = req;
    ovf_set = wr_data & fifo_full;
`else
    accept  = req & ~(wr_data & fifo_full);
    ovf_set = 1'b0;
`endif
    // Full is judged on the registered count: a same-edge pop never frees room.
    fifo_push = wr_data & ~fifo_full;
    stat_rd   = accept & ~bus_we_i & (sel == BUS_STAT);
  end

  // CPU-side response, re-arm and sticky flag next-state.
  always_comb begin
    armed_d = armed_q;
    rdy_d   = 1'b0;
    rdata_d = '0;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    if (accept) begin
      armed_d = 1'b0;
      rdy_d   = 1'b1;
      if (stat_rd) rdata_d = build_status(fifo_empty, fifo_full, ovf_q, tmo_q, fifo_count);
    end else if (!bus_ce_i) begin
      armed_d = 1'b1;
    end
    // A read clears only what it returned; an event on the same edge survives.
    if (stat_rd) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (tmo_set) tmo_d = 1'b1;
  end

  // Drain FSM: pop into the device, wait for ready or timeout, then one idle gap.
  always_comb begin
    state_d  = state_q;
    ce_d     = ce_q;
    we_d     = we_q;
    sdata_d  = sdata_q;
    timer_d  = timer_q;
    fifo_pop = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      SC_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sdata_d  = {{(DATA_W-8){1'b0}}, fifo_dout};
          ce_d     = 1'b1;
          we_d     = 1'b1;
          timer_d  = '0;
          state_d  = SC_SEND;
        end
      end
      SC_SEND: begin
        if (serail_ready_i) begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          state_d = SC_GAP;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          tmo_set = 1'b1;
          state_d = SC_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SC_GAP:  state_d = SC_IDLE;
      default: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        state_d = SC_IDLE;
      end
    endcase
  end

  // All bridge state and outputs, cleared asynchronously (ce drops at once).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b1;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      state_q <= SC_IDLE;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      sdata_q <= '0;
      timer_q <= '0;
    end else begin
      armed_q <= armed_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      sdata_q <= sdata_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_serail_ctrl.sv
// Directed bench for serail_ctrl with a simple serial device model.
module tb_serail_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 31;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              bus_ce_i = 1'b0;
  logic              bus_we_i = 1'b0;
  logic [ADDR_W-1:0] bus_addr_i = '0;
  logic [DATA_W-1:0] bus_data_i = '0;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_ready_o;
  logic              serail_ce_o;
  logic              serail_we_o;
  logic [ADDR_W-1:0] serail_addr_o;
  logic [DATA_W-1:0] serail_data_o;
  logic              serail_ready_i;

  always #5 clk = ~clk;

  serail_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_ce_i(bus_ce_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
    .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_ready_o(bus_ready_o),
    .serail_ce_o(serail_ce_o), .serail_we_o(serail_we_o), .serail_addr_o(serail_addr_o),
    .serail_data_o(serail_data_o), .serail_ready_i(serail_ready_i)
  );

  // Device model: answers ready one cycle after seeing ce, holds it until ce drops.
  logic dev_en = 1'b0;
  logic dev_ready;
  assign serail_ready_i = dev_ready;
  always @(posedge clk or negedge rst) begin
    if (!rst) dev_ready <= 1'b0;
    else      dev_ready <= serail_ce_o & dev_en;
  end

  // Monitors: received bytes, ce rising edges, ready pulses, last ce-high run.
  logic [7:0] rx [$];
  int   ce_rises = 0, rdy_pulses = 0, run_len = 0, last_run = 0;
  logic ce_prev = 1'b0;
  always @(posedge clk) begin
    if (serail_ce_o && serail_we_o && serail_ready_i) rx.push_back(serail_data_o[7:0]);
    if (serail_ce_o && !ce_prev) ce_rises++;
    if (bus_ready_o) rdy_pulses++;
    if (serail_ce_o) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    ce_prev = serail_ce_o;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access; gives up after maxc cycles, then leaves ce low for a cycle.
  task automatic bus_access(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            input int maxc, output logic ok, output logic [31:0] rd,
                            output int lat);
    bus_ce_i   = 1'b1;
    bus_we_i   = we;
    bus_addr_i = addr;
    bus_data_i = wd;
    ok  = 1'b0;
    rd  = '0;
    lat = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus_ready_o) begin
        ok = 1'b1;
        rd = bus_data_o;
        break;
      end
    end
    bus_ce_i = 1'b0;
    bus_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n, input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rx.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ce(input logic lvl, input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (serail_ce_o == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic [31:0] rd;
    int          lat, p0, base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_ready", bus_ready_o, 0);
    chk("rst_bus_data", bus_data_o, 0);
    chk("rst_sce", serail_ce_o, 0);
    chk("rst_swe", serail_we_o, 0);
    chk("rst_sdata", serail_data_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Test 1: two back-to-back bytes with a responsive device
    dev_en = 1'b1;
    bus_access(1'b1, 4'h0, 32'h41, 4, ok, rd, lat);
    chk("t1_ack0", ok, 1);
    chk("t1_lat0", lat, 1);
    bus_access(1'b1, 4'h0, 32'h42, 4, ok, rd, lat);
    chk("t1_ack1", ok, 1);
    chk("t1_ready_pulses", rdy_pulses, 2);
    wait_rx(2, 40, ok);
    chk("t1_rx_done", ok, 1);
    chk("t1_rx0", rx[0], 8'h41);
    chk("t1_rx1", rx[1], 8'h42);
    chk("t1_ce_rises", ce_rises, 2);
    chk("t1_saddr", serail_addr_o, 0);
    repeat (2) @(posedge clk);
    #1;
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t1_status", rd, 32'h0000_0001);

    // Data read, unmapped write and read
    bus_access(1'b0, 4'h0, 32'h0, 4, ok, rd, lat);
    chk("rd_data_zero", rd, 0);
    bus_access(1'b1, 4'h8, 32'h99, 4, ok, rd, lat);
    chk("unmapped_wr_ack", ok, 1);
    bus_access(1'b0, 4'h8, 32'h0, 4, ok, rd, lat);
    chk("unmapped_rd_ack", ok, 1);
    chk("unmapped_rd_data", rd, 0);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("unmapped_no_push", rd, 32'h0000_0001);

    // Test 6: one ce held 5 cycles, behind a byte stuck in SEND
    dev_en = 1'b0;
    bus_access(1'b1, 4'h0, 32'h55, 4, ok, rd, lat);
    chk("t6_first_ack", ok, 1);
    p0 = rdy_pulses;
    bus_ce_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 4'h0; bus_data_i = 32'h66;
    repeat (5) @(posedge clk);
    #1;
    bus_ce_i = 1'b0; bus_we_i = 1'b0;
    @(posedge clk); #1;
    chk("t6_one_pulse", rdy_pulses - p0, 1);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t6_status_cnt1", rd, 32'h0000_0100);

    // Test 4: timeout of the stuck byte, next byte follows
    wait_ce(1'b0, 80, ok);
    chk("t4_ce_fell", ok, 1);
    @(posedge clk); #1;
    chk("t4_ce_high_len", last_run, TIMEOUT + 1);
    wait_ce(1'b1, 10, ok);
    chk("t4_next_send", ok, 1);
    chk("t4_next_byte", serail_data_o, 32'h66);
    chk("t4_abandoned", rx.size(), 2);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t4_status_tmo", rd, 32'h0000_0009);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t4_status_clr", rd, 32'h0000_0001);
    dev_en = 1'b1;
    wait_rx(3, 10, ok);
    chk("t4_rx_done", ok, 1);
    chk("t4_rx2", rx[2], 8'h66);
    repeat (3) @(posedge clk);
    #1;

    // Test 2/3: fill with the device stalled
    dev_en = 1'b0;
    p0 = 0;
    for (int i = 0; i < 9; i++) begin
      bus_access(1'b1, 4'h0, 32'h10 + i, 4, ok, rd, lat);
      if (ok) p0++;
    end
    chk("t2_acks", p0, 9);
`ifdef SERAIL_CTRL_DROP_ON_FULL_EN
    bus_access(1'b1, 4'h0, 32'h19, 4, ok, rd, lat);
    chk("t3_drop_ack", ok, 1);
    chk("t3_drop_lat", lat, 1);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t3_status_ovf", rd, 32'h0000_0806);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t3_status_ovf_clr", rd, 32'h0000_0802);
    dev_en = 1'b1;
    wait_rx(12, 100, ok);
    chk("t3_rx_done", ok, 1);
    chk("t3_rx_first", rx[3], 8'h10);
    chk("t3_rx_last", rx[rx.size()-1], 8'h18);
`else
    bus_access(1'b1, 4'h0, 32'h19, 4, ok, rd, lat);
    chk("t2_stall", ok, 0);
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t2_status_full", rd, 32'h0000_0802);
    dev_en = 1'b1;
    bus_access(1'b1, 4'h0, 32'h19, 30, ok, rd, lat);
    chk("t2_late_ack", ok, 1);
    chk("t2_late_lat", lat > 1, 1);
    wait_rx(13, 100, ok);
    chk("t2_rx_done", ok, 1);
    chk("t2_rx_first", rx[3], 8'h10);
    chk("t2_rx_last", rx[rx.size()-1], 8'h19);
`endif
    repeat (3) @(posedge clk);
    #1;
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t2_status_drained", rd, 32'h0000_0001);

    // Test 5: asynchronous reset in the middle of a SEND and a ready pulse
    dev_en = 1'b0;
    bus_access(1'b1, 4'h0, 32'h77, 4, ok, rd, lat);
    wait_ce(1'b1, 10, ok);
    chk("t5_send", ok, 1);
    bus_ce_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 4'h4;
    @(posedge clk); #1;
    chk("t5_rdy_before", bus_ready_o, 1);
    chk("t5_sce_before", serail_ce_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_sce_async", serail_ce_o, 0);
    chk("t5_rdy_async", bus_ready_o, 0);
    bus_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    base = ce_rises;
    @(posedge clk); #1;
    bus_access(1'b0, 4'h4, 32'h0, 4, ok, rd, lat);
    chk("t5_status_after", rd, 32'h0000_0001);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_replay", ce_rises - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
